// File: rtl/int_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_cfg_pkg : register map offsets and helpers for int_cfg_bank      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package int_cfg_pkg;

  localparam int OFS_ENABLE    = 0;
  localparam int OFS_PENDING   = 1;
  localparam int OFS_THRESHOLD = 2;
  localparam int OFS_CLAIM     = 3;
  localparam int OFS_PRIO_BASE = 4;

  // Wide enough to hold source index + 1, with 0 reserved for "none".
  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_prio_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_prio_arb : combinational max-priority selector, lowest index     |
// | wins ties. rev 1.0                                                   |
// +----------------------------------------------------------------------+
module int_prio_arb
  import int_cfg_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]        cand_i,
  input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
  output logic [ID_W-1:0]           id_o,
  output logic                      valid_o
);

  logic [PRIO_W-1:0] w_best;

  // Strictly-greater replacement keeps the earliest index on equal priority.
  always_comb begin
    w_best  = '0;
    id_o    = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand_i[i] && (!valid_o || prio_i[i*PRIO_W +: PRIO_W] > w_best)) begin
        w_best  = prio_i[i*PRIO_W +: PRIO_W];
        id_o    = ID_W'(i + 1);
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_cfg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | int_cfg_bank : interrupt enable/priority/pending/threshold register  |
// | bank with registered highest-priority request. rev 1.0               |
// +----------------------------------------------------------------------+
module int_cfg_bank
  import int_cfg_pkg::*;
#(
  parameter int                 DATA_W    = 64,
  parameter int                 NUM_SRC   = 16,
  parameter int                 PRIO_W    = 3,
  parameter int                 ADDR_W    = 6,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reg_en,
  input  logic                        reg_sel,
  input  logic                        reg_wr,
  input  logic [ADDR_W-1:0]           reg_addr,
  input  logic [DATA_W-1:0]           reg_wdata,
  input  logic [DATA_W/8-1:0]         reg_wstrb,
  output logic [DATA_W-1:0]           reg_rdata,
  output logic                        reg_rvalid,
  output logic                        reg_err,
  input  logic [NUM_SRC-1:0]          src_i,
  output logic                        irq_o,
  output logic [id_width(NUM_SRC)-1:0] irq_id_o
);

  localparam int IDW       = id_width(NUM_SRC);
  localparam int NBYTES    = DATA_W / 8;
  localparam int NUM_WORDS = OFS_PRIO_BASE + NUM_SRC;

  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [PRIO_W-1:0]  thresh_q, thresh_d;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [DATA_W-1:0]  rdata_q;
  logic               rvalid_q, err_q, irq_q;
  logic [IDW-1:0]     irq_id_q;

  int                    w_addr;
  logic                  w_access, w_wr_acc, w_rd_acc, w_mapped;
  logic [DATA_W-1:0]     w_wmask, w_rd_word;
  logic [NUM_SRC-1:0]    w_src_set, w_clr, w_cand;
  logic [NUM_SRC*PRIO_W-1:0] w_prio_flat;
  logic [IDW-1:0]        w_arb_id;
  logic                  w_arb_valid;

  assign w_addr   = int'(reg_addr);
  assign w_access = reg_en && reg_sel;
  assign w_mapped = w_addr < NUM_WORDS;
  assign w_wr_acc = w_access && reg_wr && w_mapped;
  assign w_rd_acc = w_access && !reg_wr;

  for (genvar b = 0; b < NBYTES; b++) begin : g_wmask
    assign w_wmask[b*8 +: 8] = {8{reg_wstrb[b]}};
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign w_src_set[i] = EDGE_MASK[i] ? (src_i[i] && !src_prev_q[i]) : src_i[i];
    assign w_prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
    assign w_cand[i] = pending_q[i] && enable_q[i] && (prio_q[i] > thresh_q);
  end

  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    w_clr    = '0;
    if (w_wr_acc) begin
      if (w_addr == OFS_ENABLE)
        enable_d = (enable_q & ~w_wmask[NUM_SRC-1:0]) |
                   (reg_wdata[NUM_SRC-1:0] & w_wmask[NUM_SRC-1:0]);
      if (w_addr == OFS_PENDING)
        w_clr = reg_wdata[NUM_SRC-1:0] & w_wmask[NUM_SRC-1:0];
      if (w_addr == OFS_THRESHOLD)
        thresh_d = (thresh_q & ~w_wmask[PRIO_W-1:0]) |
                   (reg_wdata[PRIO_W-1:0] & w_wmask[PRIO_W-1:0]);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_addr == OFS_PRIO_BASE + i)
          prio_d[i] = (prio_q[i] & ~w_wmask[PRIO_W-1:0]) |
                      (reg_wdata[PRIO_W-1:0] & w_wmask[PRIO_W-1:0]);
      end
    end
    // A hardware set beats a same-cycle W1C clear.
    pending_d = (pending_q & ~w_clr) | w_src_set;
  end

  always_comb begin
    w_rd_word = '0;
    if (w_addr == OFS_ENABLE)         w_rd_word[NUM_SRC-1:0] = enable_q;
    else if (w_addr == OFS_PENDING)   w_rd_word[NUM_SRC-1:0] = pending_q;
    else if (w_addr == OFS_THRESHOLD) w_rd_word[PRIO_W-1:0]  = thresh_q;
    else if (w_addr == OFS_CLAIM)     w_rd_word[IDW-1:0]     = irq_id_q;
    else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_addr == OFS_PRIO_BASE + i) w_rd_word[PRIO_W-1:0] = prio_q[i];
      end
    end
  end

  int_prio_arb #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .ID_W    (IDW)
  ) u_arb (
    .cand_i  (w_cand),
    .prio_i  (w_prio_flat),
    .id_o    (w_arb_id),
    .valid_o (w_arb_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q   <= '0;
      pending_q  <= '0;
      src_prev_q <= '0;
      thresh_q   <= '0;
      prio_q     <= '{default: '0};
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      src_prev_q <= src_i;
      thresh_q   <= thresh_d;
      prio_q     <= prio_d;
      rvalid_q   <= w_rd_acc;
      err_q      <= w_access && !w_mapped;
      if (w_rd_acc) rdata_q <= w_rd_word;
      irq_q      <= w_arb_valid;
      irq_id_q   <= w_arb_id;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign reg_err    = err_q;
  assign irq_o      = irq_q;
  assign irq_id_o   = irq_id_q;

endmodule
`default_nettype wire
